decode_writeback: RTL and testbench

DECODE_WRITEBACK -- requirements
Module: decode_writeback

---
 rtl/decode_writeback_pkg.sv | 39 +++
 rtl/decode_writeback_regfile.sv | 46 ++++
 rtl/decode_writeback.sv | 119 +++++++++++
 tb/tb_decode_writeback.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_writeback_pkg.sv
// rtl/decode_writeback_pkg.sv - shared icode, register ID and status definitions
package decode_writeback_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    STAT_INS = 2'd0,
    STAT_AOK = 2'd1,
    STAT_HLT = 2'd2,
    STAT_ADR = 2'd3
  } stat_t;

  // Sticky status: once out of AOK nothing changes; address faults outrank
  // invalid instructions, which outrank halt.
  function automatic stat_t next_stat(input stat_t cur, input logic imem_err,
                                      input logic dmem_err, input logic instr_valid,
                                      input logic halt);
    if (cur != STAT_AOK)         return cur;
    if (imem_err || dmem_err)    return STAT_ADR;
    if (!instr_valid)            return STAT_INS;
    if (halt)                    return STAT_HLT;
    return STAT_AOK;
  endfunction

endpackage

// File: rtl/decode_writeback_regfile.sv
// rtl/decode_writeback_regfile.sv - 15x64 register file, 2 read, 2 write, debug port
module decode_writeback_regfile
  import decode_writeback_pkg::*;
#(
  parameter logic [63:0] STACK_INIT = 64'd256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m,
  input  logic [3:0]  dbg_sel,
  output logic [63:0] dbg_val
);

  logic [63:0] regs [0:14];

  // Reads are purely combinational, so a same-cycle write is seen only after the edge
  assign val_a   = (src_a == RNONE) ? 64'd0 : regs[src_a];
  assign val_b   = (src_b == RNONE) ? 64'd0 : regs[src_b];
  assign dbg_val = (dbg_sel == RNONE) ? 64'd0 : regs[dbg_sel];

  // Write-back; port M takes precedence when both ports target the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (4'(i) == RRSP) ? STACK_INIT : 64'd0;
      end
    end else if (we) begin
      for (int i = 0; i < 15; i++) begin
        if (dst_m == 4'(i)) begin
          regs[i] <= val_m;
        end else if (dst_e == 4'(i)) begin
          regs[i] <= val_e;
        end
      end
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// rtl/decode_writeback.sv - register decode, write-back and processor status
module decode_writeback
  import decode_writeback_pkg::*;
#(
  parameter logic [63:0] STACK_INIT = 64'd256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        halt,
  input  logic        instructionValid,
  input  logic        imemError,
  input  logic        dmemError,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [1:0]  stat,
  input  logic [3:0]  dbgSel,
  output logic [63:0] dbgVal
);

  stat_t stat_q;
  stat_t stat_nxt;
  logic  wr_en;

  // Register-ID decode; anything not listed (including unknown icodes) uses no register
  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      IRRMOVQ: begin
        srcA = rA;
        dstE = cnd ? rB : RNONE;
      end
      IIRMOVQ: dstE = rB;
      IRMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      IMRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      IOPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      ICALL: begin
        srcB = RRSP;
        dstE = RRSP;
      end
      IRET: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
      end
      IPUSHQ: begin
        srcA = rA;
        srcB = RRSP;
        dstE = RRSP;
      end
      IPOPQ: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
        dstM = rA;
      end
      IHALT, INOP, IJXX: ;
      default: ;
    endcase
  end

  // Writes only while running and not in the cycle a fault or halt is detected
  always_comb begin
    stat_nxt = next_stat(stat_q, imemError, dmemError, instructionValid, halt);
    wr_en    = (stat_q == STAT_AOK) && (stat_nxt == STAT_AOK);
  end

  // Sticky status register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= STAT_AOK;
    end else begin
      stat_q <= stat_nxt;
    end
  end

  assign stat = stat_q;

  decode_writeback_regfile #(
    .STACK_INIT (STACK_INIT)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .src_a   (srcA),
    .src_b   (srcB),
    .val_a   (valA),
    .val_b   (valB),
    .dst_e   (dstE),
    .val_e   (valE),
    .dst_m   (dstM),
    .val_m   (valM),
    .dbg_sel (dbgSel),
    .dbg_val (dbgVal)
  );

endmodule

// File: tb/tb_decode_writeback.sv
// tb/tb_decode_writeback.sv - randomized self-checking bench for decode_writeback
module tb_decode_writeback;

  localparam logic [1:0] AOK = 2'd1, HLT = 2'd2, ADR = 2'd3, INS = 2'd0;

  logic        clk;
  logic        rst_n;
  logic [3:0]  icode, rA, rB;
  logic        cnd;
  logic [63:0] valE, valM;
  logic        halt, instructionValid, imemError, dmemError;
  logic [63:0] valA, valB;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [1:0]  stat;
  logic [3:0]  dbgSel;
  logic [63:0] dbgVal;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] m_regs [16];
  logic [1:0]  m_stat;

  decode_writeback dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
    .valE(valE), .valM(valM), .halt(halt), .instructionValid(instructionValid),
    .imemError(imemError), .dmemError(dmemError), .valA(valA), .valB(valB),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM), .stat(stat),
    .dbgSel(dbgSel), .dbgVal(dbgVal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_decode(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                              input logic c, output logic [3:0] sa, output logic [3:0] sb,
                              output logic [3:0] de, output logic [3:0] dm);
    sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra : (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
    sb = (ic inside {4'h4, 4'h5, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    de = ((ic inside {4'h3, 4'h6}) || (ic == 4'h2 && c)) ? rb :
         (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    dm = (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
    m_regs[4] = 64'd256;
    m_stat = AOK;
  endtask

  task automatic model_step();
    logic [3:0] sa, sb, de, dm;
    if (m_stat == AOK) begin
      if (imemError || dmemError)  m_stat = ADR;
      else if (!instructionValid)  m_stat = INS;
      else if (halt)               m_stat = HLT;
      else begin
        model_decode(icode, rA, rB, cnd, sa, sb, de, dm);
        if (de != 4'hF) m_regs[de] = valE;
        if (dm != 4'hF) m_regs[dm] = valM;
      end
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic [63:0] ve, input logic [63:0] vm);
    icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm;
  endtask

  task automatic flags(input logic h, input logic iv, input logic ie, input logic de);
    halt = h; instructionValid = iv; imemError = ie; dmemError = de;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [63:0] exp;
    flags(0, 1, 0, 0);
    drive(4'h1, 4'hF, 4'hF, 0, 0, 0);
    do_reset();
    n_vec++;
    if (stat !== AOK) begin n_bad++; $display("FAIL reset_stat: got %0d want %0d", stat, AOK); end
    for (int r = 0; r < 16; r++) begin
      dbgSel = 4'(r); #1;
      exp = (r == 4) ? 64'd256 : 64'd0;
      n_vec++;
      if (dbgVal !== exp) begin n_bad++; $display("FAIL reset_reg%0d: got %0h want %0h", r, dbgVal, exp); end
    end
  endtask

  task automatic test_irmovq_opq();
    drive(4'h3, 4'hF, 4'h2, 0, 64'd42, 64'd0);
    clk_edge();
    dbgSel = 4'h2; #1;
    n_vec++;
    if (dbgVal !== 64'd42) begin n_bad++; $display("FAIL irmovq_reg2: got %0h want 2a", dbgVal); end
    drive(4'h6, 4'h2, 4'h2, 0, 64'd100, 64'd0); #1;
    n_vec++;
    if (valA !== 64'd42 || valB !== 64'd42) begin
      n_bad++; $display("FAIL opq_read: got %0h/%0h want 2a/2a", valA, valB);
    end
    n_vec++;
    if (srcA !== 4'h2 || srcB !== 4'h2 || dstE !== 4'h2 || dstM !== 4'hF) begin
      n_bad++; $display("FAIL opq_ids: got %h%h%h%h want 222f", srcA, srcB, dstE, dstM);
    end
    clk_edge();
  endtask

  task automatic test_cmov();
    drive(4'h2, 4'h1, 4'h3, 0, 64'd7, 64'd0); #1;
    n_vec++;
    if (dstE !== 4'hF) begin n_bad++; $display("FAIL cmov_nc_dste: got %h want f", dstE); end
    clk_edge();
    dbgSel = 4'h3; #1;
    n_vec++;
    if (dbgVal !== 64'd0) begin n_bad++; $display("FAIL cmov_nc_reg3: got %0h want 0", dbgVal); end
    cnd = 1'b1;
    clk_edge();
    dbgSel = 4'h3; #1;
    n_vec++;
    if (dbgVal !== 64'd7) begin n_bad++; $display("FAIL cmov_c_reg3: got %0h want 7", dbgVal); end
  endtask

  task automatic test_popq_rsp();
    drive(4'hB, 4'h4, 4'hF, 0, 64'd264, 64'd99); #1;
    n_vec++;
    if (dstE !== 4'h4 || dstM !== 4'h4) begin
      n_bad++; $display("FAIL popq_ids: got %h/%h want 4/4", dstE, dstM);
    end
    clk_edge();
    dbgSel = 4'h4; #1;
    n_vec++;
    if (dbgVal !== 64'd99) begin n_bad++; $display("FAIL popq_rsp: got %0h want 63", dbgVal); end
  endtask

  task automatic test_read_during_write();
    drive(4'h6, 4'hD, 4'hD, 0, 64'h1234_5678_9abc_def0, 64'd0); #1;
    n_vec++;
    if (valA !== 64'd0) begin n_bad++; $display("FAIL rdw_pre: got %0h want 0", valA); end
    @(posedge clk); model_step(); #1;
    n_vec++;
    if (valA !== 64'h1234_5678_9abc_def0) begin
      n_bad++; $display("FAIL rdw_post: got %0h want 123456789abcdef0", valA);
    end
    @(negedge clk);
  endtask

  task automatic test_halt();
    drive(4'h0, 4'hF, 4'hF, 0, 0, 0);
    flags(1, 1, 0, 0);
    clk_edge();
    n_vec++;
    if (stat !== HLT) begin n_bad++; $display("FAIL halt_stat: got %0d want %0d", stat, HLT); end
    drive(4'h3, 4'hF, 4'h5, 0, 64'd1, 0);
    flags(0, 1, 0, 0);
    clk_edge();
    dbgSel = 4'h5; #1;
    n_vec++;
    if (dbgVal !== 64'd0) begin n_bad++; $display("FAIL halt_nowrite: got %0h want 0", dbgVal); end
    n_vec++;
    if (stat !== HLT) begin n_bad++; $display("FAIL halt_sticky: got %0d want %0d", stat, HLT); end
    do_reset();
    n_vec++;
    if (stat !== AOK) begin n_bad++; $display("FAIL halt_reset: got %0d want %0d", stat, AOK); end
  endtask

  task automatic test_faults();
    drive(4'h3, 4'hF, 4'h6, 0, 64'd77, 0);
    flags(0, 0, 1, 0);
    clk_edge();
    dbgSel = 4'h6; #1;
    n_vec++;
    if (stat !== ADR) begin n_bad++; $display("FAIL adr_stat: got %0d want %0d", stat, ADR); end
    n_vec++;
    if (dbgVal !== 64'd0) begin n_bad++; $display("FAIL adr_reg6: got %0h want 0", dbgVal); end
    flags(0, 1, 0, 0);
    clk_edge();
    dbgSel = 4'h6; #1;
    n_vec++;
    if (stat !== ADR || dbgVal !== 64'd0) begin
      n_bad++; $display("FAIL adr_sticky: got %0d/%0h want %0d/0", stat, dbgVal, ADR);
    end
    do_reset();
    drive(4'h0, 4'hF, 4'hF, 0, 0, 0);
    flags(1, 0, 0, 0);
    clk_edge();
    n_vec++;
    if (stat !== INS) begin n_bad++; $display("FAIL ins_over_hlt: got %0d want %0d", stat, INS); end
    do_reset();
    drive(4'h3, 4'hF, 4'h6, 0, 64'd5, 0);
    flags(1, 0, 0, 1);
    clk_edge();
    n_vec++;
    if (stat !== ADR) begin n_bad++; $display("FAIL dmem_adr: got %0d want %0d", stat, ADR); end
    flags(0, 1, 0, 0);
    do_reset();
  endtask

  task automatic test_reset_mid();
    drive(4'h3, 4'hF, 4'h7, 0, 64'd5, 0);
    flags(0, 1, 0, 0);
    #2 rst_n = 1'b0;
    dbgSel = 4'h4; #1;
    n_vec++;
    if (dbgVal !== 64'd256) begin n_bad++; $display("FAIL midrst_rsp: got %0h want 100", dbgVal); end
    @(posedge clk); #1;
    dbgSel = 4'h7; #1;
    n_vec++;
    if (dbgVal !== 64'd0) begin n_bad++; $display("FAIL midrst_abort: got %0h want 0", dbgVal); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clk_edge();
    dbgSel = 4'h7; #1;
    n_vec++;
    if (dbgVal !== 64'd5) begin n_bad++; $display("FAIL midrst_first: got %0h want 5", dbgVal); end
  endtask

  task automatic test_random();
    logic [3:0] sa, sb, de, dm, r;
    for (int n = 0; n < 400; n++) begin
      if (m_stat != AOK && $urandom_range(0, 3) == 0) do_reset();
      drive(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom});
      flags(icode == 4'h0, $urandom_range(0, 63) != 0,
            $urandom_range(0, 63) == 0, $urandom_range(0, 63) == 0);
      #1;
      model_decode(icode, rA, rB, cnd, sa, sb, de, dm);
      n_vec++;
      if ({srcA, srcB, dstE, dstM} !== {sa, sb, de, dm}) begin
        n_bad++; $display("FAIL rnd_ids ic=%h: got %h%h%h%h want %h%h%h%h",
                          icode, srcA, srcB, dstE, dstM, sa, sb, de, dm);
      end
      n_vec++;
      if (valA !== m_regs[sa] || valB !== m_regs[sb]) begin
        n_bad++; $display("FAIL rnd_read: got %0h/%0h want %0h/%0h", valA, valB, m_regs[sa], m_regs[sb]);
      end
      clk_edge();
      n_vec++;
      if (stat !== m_stat) begin n_bad++; $display("FAIL rnd_stat: got %0d want %0d", stat, m_stat); end
      r = 4'($urandom);
      dbgSel = r; #1;
      n_vec++;
      if (dbgVal !== m_regs[r]) begin
        n_bad++; $display("FAIL rnd_reg%0d: got %0h want %0h", r, dbgVal, m_regs[r]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    dbgSel = 4'h0;
    drive(4'h1, 4'hF, 4'hF, 0, 0, 0);
    flags(0, 1, 0, 0);
    model_reset();
    test_reset();
    test_irmovq_opq();
    test_cmov();
    test_popq_rsp();
    test_read_during_write();
    test_halt();
    test_faults();
    test_reset_mid();
    do_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
